// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and clear-FSM state type
// for the multi-port register file.
package reg_file_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// reg_file_clr_ctrl: sequential clear engine that sweeps
// every address once after reset or on a clear request.
module reg_file_clr_ctrl
  import reg_file_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);

  rf_state_e   state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;

  // State and sweep counter; reset restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a request in CLEAR is ignored, no restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RF_IDLE;
        end
      end
      default: begin
        state_d = RF_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: one zero-write per edge while clearing.
  always_comb begin
    busy_o     = (state_q == RF_CLEAR);
    clr_we_o   = busy_o;
    clr_addr_o = cnt_q[AW-1:0];
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file
// with hardwired x0, optional write bypass and clear engine.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                reg_write,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rd_data,
  input  logic                clr_req,
  output logic                busy
);

  localparam int DEPTH = 2 ** AW;
  localparam bit BYP   = (BYPASS != 0);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr_ok;

  reg_file_clr_ctrl #(
    .AW (AW)
  ) u_clr (
    .clk        (clk),
    .rst        (rst),
    .clr_req_i  (clr_req),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // A clear request in the same cycle drops the user write.
  assign wr_ok = reg_write && !busy && !clr_req
              && (rd_addr != '0);

  // Array update: the clear sweep has priority.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem_q[rd_addr] <= rd_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra  = rs_addr[i*AW +: AW];
    assign hit = BYP && wr_ok && (ra == rd_addr);

    assign rs_data[i*XLEN +: XLEN] =
      (busy || ra == '0) ? '0 :
      hit                ? rd_data :
                           mem_q[ra];
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the RV32I core; successor to the fixed 32×32, two-read, one-write `reg_file`. Adds configurable width, address width and read-port count, optional write-to-read bypass, hardwired x0, and a sequential clear engine that zeroes the array after reset or on request. The decode stage drives it, and the execute stage consumes the read data.

## Interface
- `XLEN`, 32: data width in bits.
- `AW`, 5: address width; `DEPTH = 2**AW` registers (derived localparam).
- `NRD`, 2: number of read ports, 1..4.
- `BYPASS`, 1: 1 means same-cycle write data is forwarded to matching read ports; 0 means reads return the stored value.
- `clk`  in  1  rising-edge clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `rs_addr`  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- `rs_data`  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- `reg_write`  in  1  write enable.
- `rd_addr`  in  AW  write address.
- `rd_data`  in  XLEN  write data.
- `clr_req`  in  1  one-cycle request to zero the whole array.
- `busy`  out  1  clear in progress; writes are dropped and reads return 0.

## Operation
- Storage: `DEPTH` × `XLEN` flops. Address 0 always reads 0. Writes to address 0 are discarded.
- Reads: combinational from `rs_addr`. Each port is independent, and all ports may read the same address.
- Write: when `reg_write` is 1, `busy` is 0 and `rd_addr` is not 0, `mem[rd_addr] <= rd_data` at the rising edge.
- Bypass, when `BYPASS` is 1: if a write qualifies and `rs_addr[i] == rd_addr`, then `rs_data[i] = rd_data` in the same cycle. The bypass never applies to address 0.
- FSM states:
  - IDLE: normal read and write.
  - CLEAR: each edge writes `mem[cnt] <= 0` and increments `cnt` (AW+1 bits).
- Transitions:
  - `rst` → CLEAR with `cnt = 0`, which gives the full reset behaviour.
  - IDLE & `clr_req` → CLEAR with `cnt = 0`.
  - CLEAR & `cnt == DEPTH-1` → IDLE.
- `busy = (state == CLEAR)`.
- While `busy` is 1, every `rs_data` port is 0, regardless of address or bypass.
- Simultaneous events:
  - `clr_req` together with `reg_write` in IDLE: the clear wins, the write is dropped and `busy` rises next cycle.
  - `clr_req` in CLEAR: ignored, and the sweep does not restart.
  - `rst` at any point, including mid-clear: state returns to CLEAR with `cnt = 0`, and the sweep restarts from 0.

## Timing
- Reset values, in the cycle after `rst` is sampled high: state CLEAR, `cnt` 0, `busy` 1, all `rs_data` 0.
- Clear length: `busy` stays high for exactly `DEPTH` edges after the first edge at which `rst` is low (or after the edge that accepted `clr_req`). It falls after the edge that clears `DEPTH-1`. For default parameters that is 32 cycles.
- Holding `rst` high keeps `cnt` at 0 and does not advance the sweep.
- Write-to-read latency:
  - 0 cycles with bypass.
  - 1 edge without bypass: the stored value is visible in the cycle after the write edge.
- No memory contents are guaranteed before the first completed clear.

## Structure
- Shared package `reg_file_pkg`:
  - default constants `XLEN_DEF = 32`, `AW_DEF = 5`;
  - clear-FSM state enum `{RF_IDLE, RF_CLEAR}`.
- Sub-module `reg_file_clr_ctrl`: owns the FSM and `cnt`, and outputs `busy`, `clr_we` and `clr_addr`. The top level holds the array, write arbitration (clear over user write), read muxes and bypass.

## Test plan
- Reset then idle: pulse `rst` for 2 cycles, then drop it → `busy` is 1 for exactly 32 cycles. During that window, `rs_data` is 0 on all ports for every `rs_addr`.
- Write then read, with `BYPASS = 0`: write x10 = 5 and x3 = 10 on consecutive cycles. Next cycle, `rs_addr` = {3, 10} → `rs_data` = {10, 5}. x1 and x2 read 0.
- Bypass, with `BYPASS = 1`: in the same cycle, `reg_write` = 1, `rd_addr` = 7, `rd_data` = 0xDEADBEEF and `rs_addr[0]` = 7 → `rs_data[0]` = 0xDEADBEEF in that cycle. Port 1 at address 8 is unaffected.
- x0 protection: write x0 = 0xFFFFFFFF, including with bypass enabled and `rs_addr` = 0 → `rs_data` is 0 both in that cycle and after the edge.
- Clear collision: x5 = 9. Assert `clr_req` together with a write of x6 = 4 → `busy` rises next cycle and stays high for 32 cycles. Afterwards, x5 and x6 both read 0.
- Reset mid-clear with `NRD = 3`, `AW = 4`: assert `rst` on the 6th cycle of a clear → the sweep restarts, and `busy` stays high for 16 cycles after `rst` falls. All three ports read 0 throughout.
